ex_stage_pipe_reg: RTL

- Parametrised ID/EX pipeline register for the 5-stage MIPS core.
- Carries NUM_FIELDS packed words per instruction (PC, PC+4, IR, Imm, RD1, RD2 by default).
- Adds valid/ready flow control, an optional one-entry skid buffer for stalls, flush-to-bubble for branches and hazards, and a stall performance counter.
- Sits between the decode stage and the ALU/execute stage.

---
 rtl/ex_stage_pipe_reg.sv | 80 ++++++++
 1 files changed

// File: rtl/ex_stage_pipe_reg.sv
// ex_stage_pipe_reg: ID/EX pipeline register with valid/ready flow control, optional skid entry, flush and stall counter
module ex_stage_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int NUM_FIELDS = 6,
    parameter int SKID       = 1,
    parameter int CNT_W      = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_FIELDS*DATA_W-1:0] out_data,
    output logic [1:0]                   occupancy,
    output logic [CNT_W-1:0]             stall_cnt
);
    localparam int W = NUM_FIELDS * DATA_W;
    typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;
    state_t state_q, state_d;
    logic [W-1:0] main_q, main_d, skid_q, skid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic in_fire, out_fire;
    assign out_valid = state_q != ST_EMPTY;
    assign in_ready  = !reset && (SKID != 0 ? state_q != ST_SKID : (!out_valid || out_ready));
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_data  = main_q;
    assign stall_cnt = stall_cnt_q;
    assign occupancy = state_q == ST_SKID ? 2'd2 : state_q == ST_FULL ? 2'd1 : 2'd0;
    always_comb begin
        state_d     = state_q;
        main_d      = main_q;
        skid_d      = skid_q;
        stall_cnt_d = (out_valid && !out_ready && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        // flush drops everything, including an input accepted this cycle
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: if (in_fire) begin
                    state_d = ST_FULL;
                    main_d  = in_data;
                end
                ST_FULL: if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    state_d = ST_SKID;
                    skid_d  = in_data;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                    main_d  = '0;
                end
                ST_SKID: if (out_fire) begin
                    state_d = ST_FULL;
                    main_d  = skid_q;
                    skid_d  = '0;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule
